// File: rtl/fractal_pkg.sv
// Shared types, widths and the iteration-to-colour mapping for the fractal scheduler.
package fractal_pkg;

  localparam int COORD_W = 10;
  localparam int ITER_W  = 8;
  localparam int ADDR_W  = 19;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    ADVANCE,
    DONE
  } state_t;

  // Points that never escaped are black; otherwise the low three bits pick a
  // colour, with 0 remapped to white so an escaped point is never black.
  function automatic logic [2:0] color_map(input logic [ITER_W-1:0] iter,
                                           input logic [ITER_W-1:0] max_iter);
    if (iter >= max_iter) begin
      return 3'b000;
    end else if (iter[2:0] == 3'b000) begin
      return 3'b111;
    end else begin
      return iter[2:0];
    end
  endfunction

endpackage

// File: rtl/fractal_scheduler_if.sv
// Job, result and frame-buffer signals between the scheduler and its neighbours.
interface fractal_scheduler_if;
  import fractal_pkg::*;

  logic                 job_valid;
  logic                 job_ready;
  logic [COORD_W-1:0]   job_x;
  logic [COORD_W-1:0]   job_y;
  logic [ITER_W-1:0]    job_max_iter;
  logic                 res_valid;
  logic                 res_ready;
  logic [ITER_W-1:0]    res_iter;
  logic                 fb_we;
  logic [ADDR_W-1:0]    fb_addr;
  logic [2:0]           fb_data;

  // Scheduler side.
  modport master (
    output job_valid, job_x, job_y, job_max_iter, res_ready, fb_we, fb_addr, fb_data,
    input  job_ready, res_valid, res_iter
  );

  // Engine / frame-buffer side.
  modport slave (
    input  job_valid, job_x, job_y, job_max_iter, res_ready, fb_we, fb_addr, fb_data,
    output job_ready, res_valid, res_iter
  );

endinterface

// File: rtl/fractal_pixel_counter.sv
// Raster position counter: column h, row v, last-pixel flag and linear address.
module fractal_pixel_counter
  import fractal_pkg::*;
#(
  parameter int H_RES = 800,
  parameter int V_RES = 600
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] h,
  output logic [COORD_W-1:0] v,
  output logic               last,
  output logic [ADDR_W-1:0]  addr
);

  logic [COORD_W-1:0] h_reg;
  logic [COORD_W-1:0] v_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic               h_end;

  assign h_end = (h_reg == COORD_W'(H_RES - 1));
  assign last  = h_end && (v_reg == COORD_W'(V_RES - 1));

  // The address is kept as a running count so v*H_RES+h needs no multiplier;
  // it only ever steps by one pixel in raster order, so the two stay equal.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_reg    <= '0;
      v_reg    <= '0;
      addr_reg <= '0;
    end else if (clear) begin
      h_reg    <= '0;
      v_reg    <= '0;
      addr_reg <= '0;
    end else if (advance) begin
      addr_reg <= addr_reg + 1'b1;
      if (h_end) begin
        h_reg <= '0;
        v_reg <= v_reg + 1'b1;
      end else begin
        h_reg <= h_reg + 1'b1;
      end
    end
  end

  assign h    = h_reg;
  assign v    = v_reg;
  assign addr = addr_reg;

endmodule

// File: rtl/fractal_scheduler.sv
// Walks every pixel of a frame, hands one job at a time to an external
// iteration engine and writes the colour-mapped result to the frame buffer.
module fractal_scheduler
  import fractal_pkg::*;
#(
  parameter int H_RES    = 800,
  parameter int V_RES    = 600,
  parameter int MAX_ITER = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         timer,
  output logic                busy,
  output logic                frame_done,
  fractal_scheduler_if.master bus
);

  localparam logic [COORD_W-1:0] H_HALF     = COORD_W'(H_RES / 2);
  localparam logic [COORD_W-1:0] V_HALF     = COORD_W'(V_RES / 2);
  localparam logic [ITER_W-1:0]  MAX_ITER_V = ITER_W'(MAX_ITER);

  state_t              state_reg;
  logic [COORD_W-1:0]  pan_reg;
  logic [ITER_W-1:0]   iter_reg;
  logic                job_valid_reg;
  logic                res_ready_reg;
  logic                fb_we_reg;
  logic [ADDR_W-1:0]   fb_addr_reg;
  logic                busy_reg;
  logic                frame_done_reg;
  logic                abort_pend_reg;

  logic                cnt_clear;
  logic                cnt_advance;
  logic [COORD_W-1:0]  h;
  logic [COORD_W-1:0]  v;
  logic                cnt_last;
  logic [ADDR_W-1:0]   cnt_addr;
  logic                abort_now;
  logic                unused_timer_bits;

  assign unused_timer_bits = ^timer[15:10];

  // An abort pulse seen anywhere in a frame is remembered until IDLE.
  assign abort_now   = abort | abort_pend_reg;
  assign cnt_clear   = (state_reg == IDLE) && start;
  assign cnt_advance = (state_reg == ADVANCE);

  fractal_pixel_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .h       (h),
    .v       (v),
    .last    (cnt_last),
    .addr    (cnt_addr)
  );

  // Frame sequencing; every handshake and status output is a register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pan_reg        <= '0;
      iter_reg       <= '0;
      job_valid_reg  <= 1'b0;
      res_ready_reg  <= 1'b0;
      fb_we_reg      <= 1'b0;
      fb_addr_reg    <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      abort_pend_reg <= 1'b0;
    end else begin
      fb_we_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      abort_pend_reg <= (state_reg != IDLE) && (abort_pend_reg || abort);
      case (state_reg)
        IDLE: begin
          if (start) begin
            pan_reg       <= timer[COORD_W-1:0];
            job_valid_reg <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          // A completed handshake wins over abort so the engine's result is
          // never orphaned; the abort is then honoured in WAIT.
          if (bus.job_ready) begin
            job_valid_reg <= 1'b0;
            res_ready_reg <= 1'b1;
            state_reg     <= WAIT;
          end else if (abort_now) begin
            job_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        WAIT: begin
          if (bus.res_valid) begin
            res_ready_reg <= 1'b0;
            iter_reg      <= bus.res_iter;
            if (abort_now) begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              fb_we_reg   <= 1'b1;
              fb_addr_reg <= cnt_addr;
              state_reg   <= WRITE;
            end
          end
        end
        WRITE: begin
          if (abort_now) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            state_reg <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (abort_now) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (cnt_last) begin
            frame_done_reg <= 1'b1;
            state_reg      <= DONE;
          end else begin
            job_valid_reg <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          job_valid_reg <= 1'b0;
          res_ready_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  // Coordinates come straight from stable registers, so they cannot move
  // while a job is stalled; outside ISSUE they read as zero.
  assign bus.job_x        = (state_reg == ISSUE) ? (h - H_HALF + pan_reg) : '0;
  assign bus.job_y        = (state_reg == ISSUE) ? (V_HALF - v) : '0;
  assign bus.job_valid    = job_valid_reg;
  assign bus.job_max_iter = MAX_ITER_V;
  assign bus.res_ready    = res_ready_reg;
  assign bus.fb_we        = fb_we_reg;
  assign bus.fb_addr      = fb_addr_reg;
  assign bus.fb_data      = (state_reg == WRITE) ? color_map(iter_reg, MAX_ITER_V) : 3'b000;
  assign busy             = busy_reg;
  assign frame_done       = frame_done_reg;

endmodule

// File: tb/tb_fractal_scheduler.sv
// Directed bench: three scheduler instances (800x600, 2x2, 4x3) share one
// engine stimulus; expected frame-buffer writes go through a scoreboard queue.
module tb_fractal_scheduler;

  localparam int N_INST = 3;

  logic              clock;
  logic              reset;
  logic [N_INST-1:0] start_a;
  logic              abort;
  logic              job_ready;
  logic              res_valid;
  logic [15:0]       timer;
  logic [7:0]        res_iter;

  logic [N_INST-1:0] job_valid_a;
  logic [N_INST-1:0] res_ready_a;
  logic [N_INST-1:0] fb_we_a;
  logic [N_INST-1:0] busy_a;
  logic [N_INST-1:0] fd_a;
  logic [9:0]        job_x_a     [N_INST];
  logic [9:0]        job_y_a     [N_INST];
  logic [18:0]       fb_addr_a   [N_INST];
  logic [2:0]        fb_data_a   [N_INST];
  logic [7:0]        max_iter_a  [N_INST];

  int          wr_cnt [N_INST] = '{0, 0, 0};
  int          fd_cnt [N_INST] = '{0, 0, 0};
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  int          exp_addr = 0;
  int          w;
  int          f;
  bit          stable;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
    localparam int HR = (gi == 0) ? 800 : (gi == 1) ? 2 : 4;
    localparam int VR = (gi == 0) ? 600 : (gi == 1) ? 2 : 3;

    fractal_scheduler_if ifc ();

    fractal_scheduler #(
      .H_RES    (HR),
      .V_RES    (VR),
      .MAX_ITER (64)
    ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start_a[gi]),
      .abort      (abort),
      .timer      (timer),
      .busy       (busy_a[gi]),
      .frame_done (fd_a[gi]),
      .bus        (ifc.master)
    );

    assign ifc.job_ready   = job_ready;
    assign ifc.res_valid   = res_valid;
    assign ifc.res_iter    = res_iter;
    assign job_valid_a[gi] = ifc.job_valid;
    assign res_ready_a[gi] = ifc.res_ready;
    assign fb_we_a[gi]     = ifc.fb_we;
    assign job_x_a[gi]     = ifc.job_x;
    assign job_y_a[gi]     = ifc.job_y;
    assign fb_addr_a[gi]   = ifc.fb_addr;
    assign fb_data_a[gi]   = ifc.fb_data;
    assign max_iter_a[gi]  = ifc.job_max_iter;
  end

  // Count write strobes and completion pulses per instance.
  always @(posedge clock) begin
    for (int i = 0; i < N_INST; i++) begin
      if (fb_we_a[i] === 1'b1) wr_cnt[i] = wr_cnt[i] + 1;
      if (fd_a[i] === 1'b1) fd_cnt[i] = fd_cnt[i] + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] c10(input int val);
    logic [9:0] t;
    t = val[9:0];
    return {22'd0, t};
  endfunction

  function automatic logic [2:0] exp_color(input int iter);
    if (iter >= 64) return 3'd0;
    if (iter % 8 == 0) return 3'd7;
    return 3'(iter % 8);
  endfunction

  task automatic check_quiet(input int k, input string tag);
    check({tag, "_job_valid"}, job_valid_a[k], 0);
    check({tag, "_res_ready"}, res_ready_a[k], 0);
    check({tag, "_fb_we"}, fb_we_a[k], 0);
    check({tag, "_busy"}, busy_a[k], 0);
    check({tag, "_frame_done"}, fd_a[k], 0);
    check({tag, "_job_x"}, job_x_a[k], 0);
    check({tag, "_job_y"}, job_y_a[k], 0);
    check({tag, "_fb_addr"}, fb_addr_a[k], 0);
    check({tag, "_fb_data"}, fb_data_a[k], 0);
  endtask

  task automatic pulse_start(input int k, input logic [15:0] t);
    timer = t;
    start_a[k] = 1'b1;
    @(negedge clock);
    start_a[k] = 1'b0;
  endtask

  task automatic wait_job(input int k);
    int n;
    n = 0;
    while (job_valid_a[k] !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("job_valid_seen", job_valid_a[k], 1);
  endtask

  // One pixel: accept the job, return iter after lat cycles, check the write.
  task automatic pixel(input int k, input logic [7:0] iter, input int lat, input bit abort_in_wait);
    logic [31:0] e;
    wait_job(k);
    job_ready = 1'b1;
    @(negedge clock);
    job_ready = 1'b0;
    check("res_ready_in_wait", res_ready_a[k], 1);
    check("single_outstanding", job_valid_a[k], 0);
    if (abort_in_wait) abort = 1'b1;
    else exp_q.push_back({10'd0, 19'(exp_addr), exp_color(int'(iter))});
    repeat (lat - 1) @(negedge clock);
    res_valid = 1'b1;
    res_iter  = iter;
    @(negedge clock);
    res_valid = 1'b0;
    check("res_consumed", res_ready_a[k], 0);
    if (abort_in_wait) begin
      check("abort_wait_no_we", fb_we_a[k], 0);
      check("abort_wait_idle", busy_a[k], 0);
      abort = 1'b0;
    end else begin
      e = exp_q.pop_front();
      check("fb_we", fb_we_a[k], 1);
      check("fb_addr", fb_addr_a[k], {13'd0, e[21:3]});
      check("fb_data", fb_data_a[k], {29'd0, e[2:0]});
      exp_addr++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    start_a   = '0;
    abort     = 1'b0;
    job_ready = 1'b0;
    res_valid = 1'b0;
    timer     = '0;
    res_iter  = '0;
    repeat (2) @(negedge clock);
    for (int k = 0; k < N_INST; k++) check_quiet(k, "reset");
    check("job_max_iter", max_iter_a[0], 64);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_waits_start", busy_a[0], 0);

    // 800x600: first job coordinates, stall, colour mapping, abort in WAIT.
    pulse_start(0, 16'h0005);
    check("first_job_one_cycle", job_valid_a[0], 1);
    check("first_job_x", job_x_a[0], c10(-395));
    check("first_job_y", job_y_a[0], c10(300));
    check("busy_in_frame", busy_a[0], 1);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (job_valid_a[0] !== 1'b1 || job_x_a[0] !== 10'(629) || job_y_a[0] !== 10'd300) stable = 1'b0;
    end
    check("stall_stable", stable, 1);
    exp_addr = 0;
    pixel(0, 8'd64, 2, 1'b0);
    wait_job(0);
    check("second_job_x", job_x_a[0], c10(-394));
    pixel(0, 8'd8, 2, 1'b0);
    pixel(0, 8'd13, 3, 1'b0);
    @(negedge clock);
    check("writes_so_far", wr_cnt[0], 3);
    w = wr_cnt[0];
    f = fd_cnt[0];
    pixel(0, 8'd20, 2, 1'b1);
    repeat (4) @(negedge clock);
    check("abort_wait_wr_cnt", wr_cnt[0], w);
    check("abort_no_frame_done", fd_cnt[0], f);
    check("abort_stays_idle", busy_a[0], 0);

    // Reset in WAIT, then restart from address 0 and abort in WRITE.
    pulse_start(0, 16'h0000);
    exp_addr = 0;
    pixel(0, 8'd1, 2, 1'b0);
    wait_job(0);
    job_ready = 1'b1;
    @(negedge clock);
    job_ready = 1'b0;
    check("reset_test_in_wait", res_ready_a[0], 1);
    w = wr_cnt[0];
    #2 reset = 1'b1;
    #1;
    check_quiet(0, "async_reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_no_write", wr_cnt[0], w);
    check("reset_waits_start", busy_a[0], 0);
    pulse_start(0, 16'h0000);
    exp_addr = 0;
    check("restart_job_x", job_x_a[0], c10(-400));
    pixel(0, 8'd9, 2, 1'b0);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_write_idle", busy_a[0], 0);
    @(negedge clock);
    check("abort_write_completed", wr_cnt[0], w + 1);

    // 2x2 frame.
    exp_addr = 0;
    w = wr_cnt[1];
    f = fd_cnt[1];
    pulse_start(1, 16'h0000);
    for (int p = 0; p < 4; p++) pixel(1, 8'(p + 1), 2, 1'b0);
    repeat (3) @(negedge clock);
    check("2x2_writes", wr_cnt[1] - w, 4);
    check("2x2_frame_done", fd_cnt[1] - f, 1);
    check("2x2_idle", busy_a[1], 0);

    // 4x3 frame with an ignored start in the middle.
    exp_addr = 0;
    w = wr_cnt[2];
    f = fd_cnt[2];
    pulse_start(2, 16'h0000);
    for (int p = 0; p < 12; p++) begin
      if (p == 5) begin
        wait_job(2);
        pulse_start(2, 16'h03FF);
        check("ignored_start_x", job_x_a[2], c10(-1));
        check("ignored_start_y", job_y_a[2], c10(0));
      end
      pixel(2, 8'(p * 3), 2, 1'b0);
    end
    @(negedge clock);
    check("4x3_no_early_done", fd_a[2], 0);
    @(negedge clock);
    check("4x3_done_pulse", fd_a[2], 1);
    check("4x3_busy_in_done", busy_a[2], 1);
    @(negedge clock);
    check("4x3_done_one_cycle", fd_a[2], 0);
    check("4x3_idle", busy_a[2], 0);
    check("4x3_writes", wr_cnt[2] - w, 12);
    check("4x3_frame_done_count", fd_cnt[2] - f, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fractal_scheduler.md
FRACTAL_SCHEDULER -- requirements
Module: fractal_scheduler

Interface
REQ-001 Parameter H_RES, default 800, pixels per line.
REQ-002 Parameter V_RES, default 600, lines per frame.
REQ-003 Parameter MAX_ITER, default 64, iteration limit passed to the engine, range 1..255.
REQ-004 clock  in  1  sole clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a frame render.
REQ-007 abort  in  1  level; stops rendering after any outstanding job drains.
REQ-008 timer  in  16  pan offset; bits [9:0] are latched at frame start.
REQ-009 job_valid  out  1  a job is presented to the iteration engine.
REQ-010 job_ready  in  1  the engine accepts the job.
REQ-011 job_x, job_y  out  10 each  signed pixel coordinates (two's complement).
REQ-012 job_max_iter  out  8  equals MAX_ITER.
REQ-013 res_valid  in  1  the engine presents a result.
REQ-014 res_ready  out  1  the scheduler accepts the result.
REQ-015 res_iter  in  8  escape iteration count.
REQ-016 fb_we, fb_addr, fb_data  out  1/19/3  frame-buffer write strobe, linear address, and RGB value.
REQ-017 busy, frame_done  out  1/1  render in progress; one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT, WRITE, ADVANCE and DONE.
REQ-019 IDLE:
- start=1 SHALL latch pan=timer[9:0].
- start=1 SHALL clear the column counter h and the row counter v.
- The FSM SHALL go to ISSUE on the next cycle.
- start=0 SHALL keep the FSM in IDLE.
REQ-020 ISSUE:
- job_valid SHALL be 1.
- job_x SHALL equal h - H_RES/2 + pan, truncated to 10 bits.
- job_y SHALL equal V_RES/2 - v, truncated to 10 bits.
- job_valid=1 with job_ready=1 SHALL cause a transition to WAIT.
- job_x and job_y SHALL hold stable while job_valid=1 and job_ready=0.
REQ-021 WAIT:
- res_ready SHALL be 1.
- res_valid=1 SHALL capture res_iter and cause a transition to WRITE.
- Only one job SHALL be outstanding at any time.
REQ-022 WRITE: the block SHALL issue a single-cycle fb_we=1 with fb_addr=v*H_RES+h.
REQ-023 WRITE: fb_data SHALL be 3'b000 if res_iter>=MAX_ITER; otherwise res_iter[2:0], with the value 3'b000 replaced by 3'b111.
REQ-024 ADVANCE, counter update: h SHALL increment; at h=H_RES-1, h SHALL wrap to 0 and v SHALL increment.
REQ-025 ADVANCE, next state: after the last pixel (h=H_RES-1, v=V_RES-1) the FSM SHALL go to DONE; otherwise it SHALL go to ISSUE.
REQ-026 DONE SHALL pulse frame_done=1 for one cycle, then go to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start asserted while busy=1 SHALL be ignored.
REQ-029 abort=1 in ISSUE before the handshake SHALL go directly to IDLE with no write.
REQ-030 abort=1 in WAIT SHALL still consume the result, skip WRITE, then go to IDLE.
REQ-031 abort=1 in WRITE or ADVANCE SHALL complete the current write, then go to IDLE.
REQ-032 An aborted frame SHALL NOT pulse frame_done.
REQ-033 Throughput SHALL be the engine latency plus 3 cycles per pixel.
REQ-034 The first job_valid SHALL assert 1 cycle after start.

Reset
REQ-035 Reset SHALL put the FSM in IDLE and clear h, v, pan and the captured res_iter to 0.
REQ-036 During reset, job_valid, res_ready, fb_we, busy and frame_done SHALL be 0; job_x, job_y, fb_addr and fb_data SHALL be 0.
REQ-037 Reset asserted mid-frame SHALL take effect immediately, with no further writes.
REQ-038 After reset deasserts, the block SHALL wait for a new start.

Structure
REQ-039 A shared package fractal_pkg SHALL hold the state enum, COORD_W=10, ITER_W=8, ADDR_W=19 and the colour-mapping function.
REQ-040 One sub-module, fractal_pixel_counter, SHALL hold h/v, the wrap logic, the last-pixel flag and the address computation.
REQ-041 The iteration engine SHALL be external to this block.

Verification
REQ-042 Reset then start with timer=16'h0005 and a 2-cycle-latency engine model -> first job has job_x=-395 and job_y=300; fb_addr=0 is written; 4 of 4 pixels are written with H_RES=2 and V_RES=2.
REQ-043 job_ready held 0 for 5 cycles -> job_valid stays 1 and job_x/job_y stay stable; exactly one job is accepted afterwards.
REQ-044 res_iter=64 with MAX_ITER=64 -> fb_data=000; res_iter=8 -> fb_data=111; res_iter=13 -> fb_data=101.
REQ-045 abort in WAIT -> the result is consumed, fb_we is never asserted, the FSM returns to IDLE and frame_done stays 0.
REQ-046 start pulsed mid-frame -> ignored, and the pixel count is unchanged; full frame with H_RES=4 and V_RES=3 -> 12 writes at addresses 0..11, then one frame_done pulse.
REQ-047 Reset asserted while in WAIT -> all outputs go to 0 asynchronously, and the next start restarts at address 0.
